// File: rtl/ttd_avg.sv
// ============================================================================
// Module   : ttd_avg
// Function : Averaging time-to-digital converter for the capacitor/comparator
//            temperature front end. Optional macro: TTD_GLITCH_FILTER_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ttd_avg #(
    parameter int CNT_WIDTH  = 9,
    parameter int RST_CYCLES = 16,
    parameter int AVG_LOG2   = 2,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 in,
    output logic                 rst_cap,
    output logic                 busy,
    output logic [OUT_WIDTH-1:0] sample_out,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 sample_timeout
);

    localparam int c_ACC_W = CNT_WIDTH + AVG_LOG2;
    localparam int c_IDX_W = AVG_LOG2 + 1;
    localparam int c_RC_W  = $clog2(RST_CYCLES + 1);
    localparam logic [c_RC_W-1:0]    c_RST_LAST = c_RC_W'(RST_CYCLES - 1);
    localparam logic [c_IDX_W-1:0]   c_NSAMP    = c_IDX_W'(2 ** AVG_LOG2);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;
    localparam logic [OUT_WIDTH-1:0] c_OUT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RESET  = 2'd1,
        S_CHARGE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_in_meta;
    logic                 r_in_s;
    logic                 r_in_d;
    logic [c_RC_W-1:0]    r_rst_cnt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_ACC_W-1:0]   r_acc;
    logic                 r_to;

    logic                 w_edge;
    logic                 w_slot_free;
    logic                 w_sample_done;
    logic [CNT_WIDTH-1:0] w_sample;
    logic [CNT_WIDTH-1:0] w_avg;
    logic [OUT_WIDTH-1:0] w_sat;
    logic [c_IDX_W-1:0]   w_idx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_meta <= 1'b0;
            r_in_s    <= 1'b0;
            r_in_d    <= 1'b0;
        end else begin
            r_in_meta <= in;
            r_in_s    <= r_in_meta;
            r_in_d    <= r_in_s;
        end
    end

`ifdef TTD_GLITCH_FILTER_EN
    // Edge only after two consecutive high samples following a low one.
    logic r_in_d2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_d2 <= 1'b0;
        end else begin
            r_in_d2 <= r_in_d;
        end
    end

    assign w_edge = r_in_s & r_in_d & ~r_in_d2;
`else
    assign w_edge = r_in_s & ~r_in_d;
`endif

    assign w_slot_free   = ~sample_valid | sample_ready;
    assign w_sample_done = w_edge | (r_cnt == c_CNT_MAX);
    assign w_sample      = w_edge ? r_cnt : c_CNT_MAX;
    assign w_idx_next    = r_idx + c_IDX_W'(1);
    assign w_avg         = r_acc[c_ACC_W-1:AVG_LOG2];

    generate
        if (OUT_WIDTH < CNT_WIDTH) begin : g_sat
            assign w_sat = (|w_avg[CNT_WIDTH-1:OUT_WIDTH]) ? c_OUT_MAX : w_avg[OUT_WIDTH-1:0];
        end else begin : g_nosat
            assign w_sat = w_avg[OUT_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            rst_cap        <= 1'b1;
            busy           <= 1'b0;
            sample_out     <= '0;
            sample_valid   <= 1'b0;
            sample_timeout <= 1'b0;
            r_rst_cnt      <= '0;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_acc          <= '0;
            r_to           <= 1'b0;
        end else begin
            // DONE below overrides this clear when both happen together.
            if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if ((start || continuous) && w_slot_free) begin
                        r_state   <= S_RESET;
                        busy      <= 1'b1;
                        r_rst_cnt <= '0;
                        r_acc     <= '0;
                        r_idx     <= '0;
                    end
                end
                S_RESET: begin
                    if (r_rst_cnt == c_RST_LAST) begin
                        r_state <= S_CHARGE;
                        rst_cap <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + c_RC_W'(1);
                    end
                end
                S_CHARGE: begin
                    if (w_sample_done) begin
                        r_acc     <= r_acc + c_ACC_W'(w_sample);
                        r_idx     <= w_idx_next;
                        rst_cap   <= 1'b1;
                        r_rst_cnt <= '0;
                        if (!w_edge) begin
                            r_to <= 1'b1;
                        end
                        r_state <= (w_idx_next == c_NSAMP) ? S_DONE : S_RESET;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    sample_out     <= w_sat;
                    sample_valid   <= 1'b1;
                    sample_timeout <= r_to;
                    r_to           <= 1'b0;
                    busy           <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    rst_cap <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ttd_avg.sv
// ============================================================================
// Module   : tb_ttd_avg
// Function : Directed, table-driven check of ttd_avg (CNT 9, RST 4, AVG 4, OUT 8).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ttd_avg;

    localparam int CW = 9;
    localparam int RC = 4;
    localparam int AL = 2;
    localparam int OW = 8;
`ifdef TTD_GLITCH_FILTER_EN
    localparam int c_LAT        = 3;
    localparam int c_GLITCH_EXP = 80;
`else
    localparam int c_LAT        = 2;
    localparam int c_GLITCH_EXP = 20;
`endif
    localparam int c_BOUND = 2000;

    logic          clk;
    logic          rst;
    logic          start;
    logic          continuous;
    logic          in;
    logic          rst_cap;
    logic          busy;
    logic [OW-1:0] sample_out;
    logic          sample_valid;
    logic          sample_ready;
    logic          sample_timeout;

    ttd_avg #(
        .CNT_WIDTH (CW),
        .RST_CYCLES(RC),
        .AVG_LOG2  (AL),
        .OUT_WIDTH (OW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .continuous    (continuous),
        .in            (in),
        .rst_cap       (rst_cap),
        .busy          (busy),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .sample_timeout(sample_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k = counter value at which the edge must be detected; -1 pin low, -2 pin high.
    typedef struct {
        int k0;
        int k1;
        int k2;
        int k3;
        int glitch;
        int exp_out;
        int exp_to;
    } vec_t;

    vec_t vecs[9];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, c_BOUND);
    endtask

    // Called at a negedge during RESET; returns at the first negedge after CHARGE ends.
    task automatic do_sample(input int k, input int glitch);
        int n;
        int cnt;
        int j;
        int kd;
        kd = (k < 0) ? 100000 : k - c_LAT;
        if (k == -2) in = 1'b1;
        cnt = 0;
        n   = 0;
        while (rst_cap && n < c_BOUND) begin
            if (busy) cnt++;
            @(negedge clk);
            n++;
        end
        if (n >= c_BOUND) bound_fail("charge_entry");
        check("rst_cap_cycles", cnt, RC);
        j = 0;
        while (!rst_cap && j < c_BOUND) begin
            if (glitch != 0 && j == 18) in = 1'b1;
            if (glitch != 0 && j == 19) in = 1'b0;
            if (j == kd) in = 1'b1;
            @(negedge clk);
            j++;
        end
        if (j >= c_BOUND) bound_fail("charge_end");
        if (k != -2) in = 1'b0;
    endtask

    task automatic wait_result(input int exp_out, input int exp_to);
        int n;
        n = 0;
        while (!sample_valid && n < c_BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= c_BOUND) begin
            bound_fail("result_valid");
        end else begin
            check("sample_out", int'(sample_out), exp_out);
            check("sample_timeout", int'(sample_timeout), exp_to);
            check("busy_after_done", int'(busy), 0);
        end
    endtask

    task automatic accept();
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check("valid_drop", int'(sample_valid), 0);
    endtask

    task automatic run_vec(input vec_t v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_sample(v.k0, v.glitch);
        do_sample(v.k1, v.glitch);
        do_sample(v.k2, v.glitch);
        do_sample(v.k3, v.glitch);
        in = 1'b0;
        wait_result(v.exp_out, v.exp_to);
        accept();
    endtask

    initial begin
        int   n;
        int   stall_ok;
        vec_t v60;

        vecs[0] = '{100, 100, 100, 100, 0, 100, 0};
        vecs[1] = '{100, 101, 102, 103, 0, 101, 0};
        vecs[2] = '{-1, -1, -1, -1, 0, 255, 1};
        vecs[3] = '{-2, -2, -2, -2, 0, 255, 1};
        vecs[4] = '{10, 20, 30, 41, 0, 25, 0};
        vecs[5] = '{50, -1, 50, 50, 0, 165, 1};
        vecs[6] = '{255, 255, 255, 255, 0, 255, 0};
        vecs[7] = '{256, 256, 256, 256, 0, 255, 0};
        vecs[8] = '{80, 80, 80, 80, 1, c_GLITCH_EXP, 0};
        v60     = '{60, 60, 60, 60, 0, 60, 0};

        rst          = 1'b1;
        start        = 1'b0;
        continuous   = 1'b0;
        in           = 1'b0;
        sample_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rst_cap", int'(rst_cap), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_sample_out", int'(sample_out), 0);
        check("rst_sample_valid", int'(sample_valid), 0);
        check("rst_sample_timeout", int'(sample_timeout), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Back-pressure in continuous mode, then a one-cycle accept restarts it.
        continuous = 1'b1;
        @(negedge clk);
        do_sample(70, 0);
        do_sample(70, 0);
        do_sample(70, 0);
        do_sample(70, 0);
        wait_result(70, 0);
        stall_ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || !rst_cap || !sample_valid || sample_out != 8'd70) stall_ok = 0;
        end
        check("bp_stall_held", stall_ok, 1);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        continuous   = 1'b0;
        check("bp_valid_drop", int'(sample_valid), 0);
        check("bp_restart_busy", int'(busy), 1);
        do_sample(90, 0);
        do_sample(90, 0);
        do_sample(90, 0);
        do_sample(90, 0);
        wait_result(90, 0);
        accept();

        // Reset while charging at counter 50.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rst_cap && n < c_BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= c_BOUND) bound_fail("abort_charge_entry");
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rst_cap", int'(rst_cap), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(sample_valid), 0);
        @(negedge clk);
        run_vec(v60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
